alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have no parameters; all datapath widths are fixed as listed below.
REQ-002 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_ni  input  1  asynchronous, active-low reset.
REQ-004 a_imm_i  input  8  immediate operand, used only by ADI.
REQ-005 a_mem_i  input  4  memory operand, zero-extended to 8 bits for all non-ADI functions.
REQ-006 b_i  input  8  accumulator operand.
REQ-007 func_i  input  3  operation select.
REQ-008 result_o  output  8  registered result.
REQ-009 fz_o  output  1  registered zero flag.
REQ-010 fc_o  output  1  registered carry/borrow flag.

Function
REQ-011 The block SHALL sample inputs every rising clk_i edge; result_o/fz_o/fc_o SHALL reflect the inputs of the previous edge (latency 1 cycle, throughput 1 op/cycle, no enable, no handshake).
REQ-012 Operand A SHALL be a_imm_i when func_i=000, else {4'b0000, a_mem_i}.
REQ-013 func_i encoding (result):
- 000 ADI: b+A
- 001 ADD: b+A
- 010 SUB: b−A
- 011 AND: b&A
- 100 ORR: b|A
- 101 XOR: b^A
- 110 LSL: b<<A[3:0]
- 111 LSR: b>>A[3:0]
All results SHALL be truncated to 8 bits.
REQ-014 ADI/ADD: fc SHALL be bit 8 of the 9-bit unsigned sum (wrap-around 0xFF+0x01 -> result 0x00, fc=1).
REQ-015 SUB: fc SHALL be 1 when A > b unsigned (borrow), else 0; the result wraps modulo 256.
REQ-016 AND/ORR/XOR: fc SHALL be 0.
REQ-017 Shift amounts 0..15 SHALL be logical, zero-filled; an amount of 0 SHALL pass b unchanged; amounts >= 8 SHALL yield 0x00.
REQ-018 fz SHALL be 1 exactly when the 8-bit result is 0x00, for every function.
REQ-019 The flags SHALL always be computed from the same operation as the result in the same cycle; there SHALL be no sticky flag state.

Reset
REQ-020 While rst_ni=0, result_o SHALL be 0x00, fz_o 1 and fc_o 0, immediately and independent of clk_i.
REQ-021 Reset asserted mid-operation SHALL discard the pending result; the first rising edge after deassertion SHALL register the then-current inputs.

Configuration
REQ-022 Macro ALU_SHIFT_CARRY_EN defined: for LSL/LSR, fc SHALL be the last bit shifted out of b (for LSL bit 8−n, for LSR bit n−1, for 1<=n<=8); fc SHALL be 0 for n=0 or n>8.
REQ-023 Macro ALU_SHIFT_CARRY_EN undefined: fc SHALL be 0 for LSL/LSR; all other behaviour is identical.

Verification
REQ-024 The bench SHALL cover the following scenarios (response checked one cycle after each stimulus):
- ADI a_imm=0x01, b=0x00 -> result 0x01, fz=0, fc=0.
- ADD a_mem=0xC, b=0x00 -> result 0x0C.
- ADI a_imm=0x01, b=0xFF -> result 0x00, fz=1, fc=1.
- SUB a_mem=0x1, b=0x01 -> result 0x00, fz=1, fc=0.
- SUB a_mem=0x2, b=0x01 -> result 0xFF, fc=1.
- AND a_mem=0x3, b=0xFF -> result 0x03.
- ORR a_mem=0xC, b=0x33 -> result 0x3F.
- XOR a_mem=0xC, b=0x55 -> result 0x59.
- LSL a_mem=0x1, b=0x81 -> result 0x02; fc=1 with ALU_SHIFT_CARRY_EN, fc=0 without.
- LSR a_mem=0x6, b=0x00 -> result 0x00, fz=1.
- LSL a_mem=0x9, b=0xFF -> result 0x00, fz=1.
- Assert rst_ni low between edges -> outputs immediately 0x00 / fz=1 / fc=0.

Source files
------------

// File: rtl/alu.sv
// rtl/alu.sv - 8-bit registered ALU, one op per cycle, latency 1.
// Optional feature: define ALU_SHIFT_CARRY_EN to report the last shifted-out bit as fc on LSL/LSR.
module alu (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] a_imm_i,
  input  logic [3:0] a_mem_i,
  input  logic [7:0] b_i,
  input  logic [2:0] func_i,
  output logic [7:0] result_o,
  output logic       fz_o,
  output logic       fc_o
);

  typedef enum logic [2:0] {
    FN_ADI = 3'b000,
    FN_ADD = 3'b001,
    FN_SUB = 3'b010,
    FN_AND = 3'b011,
    FN_ORR = 3'b100,
    FN_XOR = 3'b101,
    FN_LSL = 3'b110,
    FN_LSR = 3'b111
  } func_e;

  logic [7:0] a_op;
  logic [3:0] shamt;
  logic [8:0] sum;
  logic [8:0] diff;
  logic [7:0] result_d, result_q;
  logic       fz_d, fz_q;
  logic       fc_d, fc_q;
`ifdef ALU_SHIFT_CARRY_EN
  logic [15:0] lsl_wide;
  logic [15:0] lsr_wide;
`endif

  always_comb begin
    a_op     = (func_e'(func_i) == FN_ADI) ? a_imm_i : {4'b0000, a_mem_i};
    shamt    = a_op[3:0];
    sum      = {1'b0, b_i} + {1'b0, a_op};
    // diff[8] is the borrow: set exactly when a_op > b_i
    diff     = {1'b0, b_i} - {1'b0, a_op};
`ifdef ALU_SHIFT_CARRY_EN
    // Widened shifts land the last bit shifted out at a fixed position (0 for n=0 or n>8)
    lsl_wide = {8'h00, b_i} << shamt;
    lsr_wide = {b_i, 8'h00} >> shamt;
`endif
    result_d = 8'h00;
    fc_d     = 1'b0;
    case (func_e'(func_i))
      FN_ADI, FN_ADD: begin
        result_d = sum[7:0];
        fc_d     = sum[8];
      end
      FN_SUB: begin
        result_d = diff[7:0];
        fc_d     = diff[8];
      end
      FN_AND: result_d = b_i & a_op;
      FN_ORR: result_d = b_i | a_op;
      FN_XOR: result_d = b_i ^ a_op;
      FN_LSL: begin
        result_d = b_i << shamt;
`ifdef ALU_SHIFT_CARRY_EN
        fc_d     = lsl_wide[8];
`endif
      end
      FN_LSR: begin
        result_d = b_i >> shamt;
`ifdef ALU_SHIFT_CARRY_EN
        fc_d     = lsr_wide[7];
`endif
      end
      default: result_d = 8'h00;
    endcase
    fz_d = (result_d == 8'h00);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q <= 8'h00;
      fz_q     <= 1'b1;
      fc_q     <= 1'b0;
    end else begin
      result_q <= result_d;
      fz_q     <= fz_d;
      fc_q     <= fc_d;
    end
  end

  assign result_o = result_q;
  assign fz_o     = fz_q;
  assign fc_o     = fc_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard bench for alu: directed corner cases plus random ops vs. arithmetic model.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] a_imm = 8'h00;
  logic [3:0] a_mem = 4'h0;
  logic [7:0] b = 8'h00;
  logic [2:0] func = 3'b000;
  logic [7:0] result;
  logic       fz;
  logic       fc;

  typedef struct {
    logic [7:0] res;
    logic       fz;
    logic       fc;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  alu dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .a_imm_i  (a_imm),
    .a_mem_i  (a_mem),
    .b_i      (b),
    .func_i   (func),
    .result_o (result),
    .fz_o     (fz),
    .fc_o     (fc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  function automatic exp_t model(input int f, input int imm, input int mem, input int bv,
                                 input string name);
    exp_t e;
    int   a;
    int   r;
    int   c;
    a = (f == 0) ? imm : mem;
    c = 0;
    case (f)
      0, 1: begin r = bv + a; c = (r > 255) ? 1 : 0; end
      2:    begin r = bv - a; c = (a > bv) ? 1 : 0; end
      3:    r = bv & a;
      4:    r = bv | a;
      5:    r = bv ^ a;
      6: begin
        r = bv * (1 << a);
`ifdef ALU_SHIFT_CARRY_EN
        if (a >= 1 && a <= 8) c = (bv / (1 << (8 - a))) % 2;
`endif
      end
      default: begin
        r = bv / (1 << a);
`ifdef ALU_SHIFT_CARRY_EN
        if (a >= 1 && a <= 8) c = (bv / (1 << (a - 1))) % 2;
`endif
      end
    endcase
    r = ((r % 256) + 256) % 256;
    e.res  = 8'(r);
    e.fz   = (r == 0);
    e.fc   = c[0];
    e.name = name;
    return e;
  endfunction

  task automatic issue(input int f, input int imm, input int mem, input int bv, input string name);
    @(negedge clk);
    func  = 3'(f);
    a_imm = 8'(imm);
    a_mem = 4'(mem);
    b     = 8'(bv);
    exp_q.push_back(model(f, imm, mem, bv, name));
  endtask

  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".result"}, int'(result), int'(e.res));
      check({e.name, ".fz"},     int'(fz),     int'(e.fz));
      check({e.name, ".fc"},     int'(fc),     int'(e.fc));
    end
  end

  initial begin
    int f;
    int waited;
    #1 rst_n = 1'b0;
    #2;
    check("reset.result", int'(result), 0);
    check("reset.fz", int'(fz), 1);
    check("reset.fc", int'(fc), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    issue(0, 8'h01, 0,   8'h00, "adi_1_0");
    issue(1, 0,     4'hC, 8'h00, "add_c_0");
    issue(0, 8'h01, 0,   8'hFF, "adi_wrap");
    issue(2, 0,     4'h1, 8'h01, "sub_zero");
    issue(2, 0,     4'h2, 8'h01, "sub_borrow");
    issue(3, 0,     4'h3, 8'hFF, "and");
    issue(4, 0,     4'hC, 8'h33, "orr");
    issue(5, 0,     4'hC, 8'h55, "xor");
    issue(6, 0,     4'h1, 8'h81, "lsl_1");
    issue(7, 0,     4'h6, 8'h00, "lsr_6_zero");
    issue(6, 0,     4'h9, 8'hFF, "lsl_9");
    issue(6, 0,     4'h0, 8'hA5, "lsl_0");
    issue(7, 0,     4'h8, 8'h80, "lsr_8");
    issue(6, 0,     4'h8, 8'h01, "lsl_8");
    issue(7, 0,     4'hF, 8'hFF, "lsr_15");

    @(posedge clk);
    #5 rst_n = 1'b0;
    #1;
    check("midrst.result", int'(result), 0);
    check("midrst.fz", int'(fz), 1);
    check("midrst.fc", int'(fc), 0);
    @(posedge clk);
    #3;
    check("heldrst.result", int'(result), 0);
    check("heldrst.fz", int'(fz), 1);
    rst_n = 1'b1;
    issue(1, 0, 4'h7, 8'h10, "post_reset");

    for (int i = 0; i < 300; i++) begin
      f = int'($urandom_range(0, 7));
      issue(f, int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 255)), $sformatf("rand%0d_f%0d", i, f));
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #5;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d responses pending, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
